// File: rtl/prores_slice_sequencer.sv
// prores_slice_sequencer: slice timeline and DC/AC VLC window generator for the ProRes encoder.
// Ports: clock/reset_n (async, active-low); slice_start + block_num request a slice;
// busy/seq_count expose the RUN timeline t; dc_vlc_* and ac_vlc_* are the stage reset,
// enable, flush and local-index windows; slice_done/start_drop/slice_err are one-cycle strobes.
module prores_slice_sequencer #(
    parameter int CW         = 16,
    parameter int MAX_BLOCKS = 32,
    parameter int DCT_LAT    = 10,
    parameter int DC_VLC_LAT = 44,
    parameter int AC_COEFS   = 63
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          slice_start,
    input  logic [CW-1:0] block_num,
    output logic          busy,
    output logic [CW-1:0] seq_count,
    output logic          dc_vlc_reset_n,
    output logic          dc_vlc_output_enable,
    output logic [CW-1:0] dc_vlc_counter,
    output logic          ac_vlc_reset_n,
    output logic          ac_vlc_output_enable,
    output logic          ac_vlc_output_flush,
    output logic [CW-1:0] ac_vlc_counter,
    output logic          slice_done,
    output logic          start_drop,
    output logic          slice_err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state, state_nx;
    logic [CW-1:0] t, b, ae, t_nx, b_nx, d0_nx, a0_nx, ae_nx;
    logic          in_range, accept, last, run_nx, dc_rst_nx, ac_rst_nx;
    // Outputs are computed from the next-cycle timeline so that the registered
    // values always reflect the t currently shown on seq_count.
    always_comb begin
        in_range  = block_num >= CW'(1) && block_num <= CW'(MAX_BLOCKS);
        accept    = slice_start && state != RUN && in_range;
        last      = state == RUN && t == ae + CW'(7);
        state_nx  = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
        t_nx      = (state == RUN && !last) ? t + CW'(1) : '0;
        b_nx      = accept ? block_num : b;
        d0_nx     = CW'(DCT_LAT) + b_nx;
        a0_nx     = d0_nx + CW'(DC_VLC_LAT);
        ae_nx     = a0_nx + CW'(AC_COEFS) * b_nx;
        run_nx    = state_nx == RUN;
        dc_rst_nx = run_nx && t_nx >= d0_nx + CW'(1) && t_nx < d0_nx + b_nx + CW'(8);
        ac_rst_nx = run_nx && t_nx >= a0_nx + CW'(1) && t_nx < ae_nx + CW'(8);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= IDLE;
            t                    <= '0;
            b                    <= '0;
            ae                   <= '0;
            dc_vlc_reset_n       <= 1'b0;
            dc_vlc_output_enable <= 1'b0;
            dc_vlc_counter       <= '0;
            ac_vlc_reset_n       <= 1'b0;
            ac_vlc_output_enable <= 1'b0;
            ac_vlc_output_flush  <= 1'b0;
            ac_vlc_counter       <= '0;
            start_drop           <= 1'b0;
            slice_err            <= 1'b0;
        end else begin
            state                <= state_nx;
            t                    <= t_nx;
            b                    <= b_nx;
            ae                   <= ae_nx;
            dc_vlc_reset_n       <= dc_rst_nx;
            dc_vlc_output_enable <= run_nx && t_nx >= d0_nx + CW'(7) && t_nx < d0_nx + b_nx + CW'(7);
            dc_vlc_counter       <= dc_rst_nx ? t_nx - (d0_nx + CW'(1)) : '0;
            ac_vlc_reset_n       <= ac_rst_nx;
            ac_vlc_output_enable <= run_nx && t_nx >= a0_nx + CW'(6) && t_nx < ae_nx + CW'(6);
            ac_vlc_output_flush  <= run_nx && t_nx == ae_nx + CW'(6);
            ac_vlc_counter       <= ac_rst_nx ? t_nx - (a0_nx + CW'(1)) : '0;
            start_drop           <= slice_start && state == RUN;
            slice_err            <= slice_start && state != RUN && !in_range;
        end
    end
    // Derived straight from flops, so still free of any input-to-output path.
    assign busy       = state == RUN;
    assign slice_done = state == DONE;
    assign seq_count  = t;
endmodule

// File: tb/tb_prores_slice_sequencer.sv
// tb_prores_slice_sequencer: directed self-checking bench for prores_slice_sequencer.
module tb_prores_slice_sequencer;
    logic        clock = 1'b0;
    logic        reset_n, slice_start;
    logic [15:0] block_num;
    logic        busy, dc_vlc_reset_n, dc_vlc_output_enable, ac_vlc_reset_n;
    logic        ac_vlc_output_enable, ac_vlc_output_flush, slice_done, start_drop, slice_err;
    logic [15:0] seq_count, dc_vlc_counter, ac_vlc_counter;
    int          vectors = 0, miscompares = 0;

    prores_slice_sequencer dut (
        .clock(clock), .reset_n(reset_n), .slice_start(slice_start), .block_num(block_num),
        .busy(busy), .seq_count(seq_count), .dc_vlc_reset_n(dc_vlc_reset_n),
        .dc_vlc_output_enable(dc_vlc_output_enable), .dc_vlc_counter(dc_vlc_counter),
        .ac_vlc_reset_n(ac_vlc_reset_n), .ac_vlc_output_enable(ac_vlc_output_enable),
        .ac_vlc_output_flush(ac_vlc_output_flush), .ac_vlc_counter(ac_vlc_counter),
        .slice_done(slice_done), .start_drop(start_drop), .slice_err(slice_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] obs();
        return {busy, dc_vlc_reset_n, dc_vlc_output_enable, ac_vlc_reset_n, ac_vlc_output_enable,
                ac_vlc_output_flush, slice_done, slice_err, start_drop};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_flags"}, obs(), 0);
        check({tag, "_seq"}, seq_count, 0);
        check({tag, "_dccnt"}, dc_vlc_counter, 0);
        check({tag, "_accnt"}, ac_vlc_counter, 0);
    endtask

    task automatic start(input int bn);
        slice_start = 1'b1;
        block_num   = 16'(bn);
        step();
        slice_start = 1'b0;
    endtask

    // Walks one RUN phase from t=0 and ends in the DONE cycle (or at an async reset at abort_at).
    task automatic run_body(input int bn, input int drop_at, input int abort_at, input int exp_flush);
        int d0 = 10 + bn;
        int a0 = d0 + 44;
        int ae = a0 + 63 * bn;
        int flush_t = -1;
        for (int t = 0; t <= ae + 7; t++) begin
            check("win", obs(), {1'b1, t >= d0 + 1 && t < d0 + bn + 8, t >= d0 + 7 && t < d0 + bn + 7,
                                 t >= a0 + 1 && t < ae + 8, t >= a0 + 6 && t < ae + 6, t == ae + 6,
                                 1'b0, 1'b0, t == drop_at + 1});
            check("seq", seq_count, t);
            check("dccnt", dc_vlc_counter, (t >= d0 + 1 && t < d0 + bn + 8) ? t - d0 - 1 : 0);
            check("accnt", ac_vlc_counter, (t >= a0 + 1 && t < ae + 8) ? t - a0 - 1 : 0);
            if (ac_vlc_output_flush) flush_t = t;
            if (t == abort_at) begin
                #3 reset_n = 1'b0;
                #1 check_idle("areset");
                return;
            end
            slice_start = (t == drop_at);
            block_num   = 16'(t % 50);
            step();
        end
        slice_start = 1'b0;
        check("flush_t", flush_t, exp_flush);
        check("done", obs(), 9'b000000100);
        check("done_seq", seq_count, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        slice_start = 1'b0;
        block_num   = '0;
        #22;
        check_idle("reset");
        reset_n = 1'b1;
        step();
        check_idle("idle");
        start(4);
        run_body(4, -5, -1, 316);
        step();
        check_idle("post_done");
        start(1);
        run_body(1, -5, -1, 124);
        start(32);
        run_body(32, -5, -1, 2108);
        start(4);
        run_body(4, 100, -1, 316);
        step();
        check_idle("post_drop");
        start(0);
        check("err0", obs(), 9'b000000010);
        step();
        check_idle("after_err0");
        start(33);
        check("err33", obs(), 9'b000000010);
        step();
        check_idle("after_err33");
        start(1);
        run_body(1, -5, -1, 124);
        start(33);
        check("err_done", obs(), 9'b000000010);
        step();
        check_idle("after_err_done");
        start(4);
        run_body(4, -5, 200, 316);
        step();
        step();
        check_idle("held");
        #3 reset_n = 1'b1;
        step();
        check_idle("released");
        start(2);
        run_body(2, -5, -1, 188);
        step();
        check_idle("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
